mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Parametrised memory access unit for the next-generation CR16 core; replaces the bare MAR/MDR/instruction-register flops with a sequenced, handshaked port.
- Serves instruction fetches and data loads/stores over a single memory port.
- Supports variable-latency memory (req/ack), byte and word accesses, sign/zero extension, misalignment detection and an ack timeout.
- Sits between the core control FSM and the memory/IO bus.

Parameters:
- DATA_W, 16, data and instruction width; must be even.
- ADDR_W, 16, byte address width.
- TIMEOUT, 64, maximum cycles in ACCESS without mem_ack before error; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  start instruction fetch; sampled only in IDLE.
- ld_req  in  1  start data load; sampled only in IDLE.
- st_req  in  1  start data store; sampled only in IDLE.
- addr_in  in  ADDR_W  byte address for fetch (PC) or load/store (register operand).
- st_data  in  DATA_W  store data.
- size_byte  in  1  1 = byte access, 0 = word; ignored for fetch, which is always word.
- ld_signed  in  1  1 = sign-extend byte loads, 0 = zero-extend.
- busy  out  1  high in ACCESS and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (misalign or timeout).
- rdata  out  DATA_W  last data-load result, extended.
- instr  out  DATA_W  last fetched instruction.
- mem_req  out  1  bus request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_be  out  2  byte-lane enables; bit0 = low byte.
- mem_addr  out  ADDR_W  registered address (MAR).
- mem_wdata  out  DATA_W  registered write data (MDR-out).
- mem_ack  in  1  bus acknowledge; read data valid in the same cycle.
- mem_rdata  in  DATA_W  bus read data.

Behaviour:
- Reset values: all outputs 0. FSM = IDLE, timeout counter = 0.
- Little-endian lanes:
  - addr[0] = 0 selects low byte [7:0]; addr[0] = 1 selects high byte.
  - Word accesses must have addr[0] = 0.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - Priority: st_req > ld_req > fetch_req. A lower-priority request is ignored, not queued; the requester holds it.
  - On accept: latch op, address, size, signed flag and store data.
  - Misaligned word op (addr_in[0] = 1, word) → ERR; no bus activity.
  - Otherwise → ACCESS.
- Store byte drive: mem_wdata = st_data[7:0] replicated on both lanes; mem_be = 01 or 10 by addr[0]. Word: mem_be = 11.
- Load/fetch drive: mem_be = 11 for word, lane-selected for byte.
- ACCESS:
  - mem_req = 1. mem_addr, mem_we, mem_be and mem_wdata are held stable until ack.
  - On mem_ack → DONE; capture in the same edge:
    - fetch: instr ← mem_rdata.
    - load: rdata ← selected lane extended to DATA_W (word loads take mem_rdata as-is).
    - store: no capture.
  - Counter increments each non-ack cycle. At count = TIMEOUT-1 with no ack → ERR; mem_req drops.
- DONE: done = 1 for one cycle → IDLE. mem_req = 0.
- ERR: err = 1 for one cycle, done = 0 → IDLE. rdata and instr unchanged.
- Latency: request accepted on edge N; mem_req high in cycle N+1; zero-wait ack gives done in cycle N+2. Back-to-back ops start no earlier than the edge after DONE.
- Hold rules:
  - rdata and instr hold until overwritten by a later successful load or fetch respectively.
  - Requests during busy are ignored.
- mem_ack outside ACCESS is ignored.
- Reset mid-operation aborts: the next edge gives IDLE with mem_req = 0 and all outputs 0, including rdata and instr.

Decomposition:
- Shared package cr16_mem_pkg:
  - state encoding localparams (IDLE = 0, ACCESS = 1, DONE = 2, ERR = 3).
  - op codes (OP_FETCH, OP_LOAD, OP_STORE).
  - lane-enable constants BE_LO = 01, BE_HI = 10, BE_WORD = 11.
- One sub-module: byte_lane_extract.
  - Combinational: selects the lane by addr[0] and sign- or zero-extends to DATA_W.
  - Reused later by the datapath for LDB-style instructions.

Test Plan:
- Zero-wait fetch: fetch_req, addr 0x0040, mem_ack immediately with mem_rdata 0xD301 → mem_req for exactly 1 cycle, mem_be = 11, done at N+2, instr = 0xD301, rdata unchanged.
- Signed byte load, high lane, 3 wait states: ld_req, addr 0x1001, size_byte = 1, ld_signed = 1, ack after 3 cycles with 0x80FF → mem_be = 10, addresses stable throughout, rdata = 0xFF80. Repeat with ld_signed = 0 → rdata = 0x0080.
- Byte store to low lane: st_req, addr 0x2000, st_data 0x12AB, size_byte = 1 → mem_we = 1, mem_be = 01, mem_wdata = 0xABAB, done pulse.
- Misaligned word load, addr 0x0003 → err pulse at N+1, mem_req never asserted, rdata and instr unchanged.
- Timeout (TIMEOUT = 4), load with no ack → mem_req high 4 cycles, then err pulse, back to IDLE; a later normal load succeeds.
- Arbitration and reset:
  - fetch_req, ld_req and st_req all high in IDLE → store serviced; fetch ignored until re-requested.
  - reset asserted in the 2nd wait cycle → next edge all outputs 0 and FSM in IDLE; a late mem_ack after reset has no effect.

Source files
------------

// File: rtl/cr16_mem_pkg.sv
// Shared definitions for the CR16 memory access path: FSM state encoding,
// operation codes, byte-lane enable constants and a lane-enable helper.
package cr16_mem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  // Little-endian lane enables: byte accesses pick the lane from addr[0].
  function automatic logic [1:0] lane_be(input logic is_byte, input logic a0);
    if (!is_byte) return BE_WORD;
    return a0 ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/byte_lane_extract.sv
// Selects one byte lane of a bus word by address bit 0 and sign- or
// zero-extends it to the full data width. Purely combinational; shared with
// the datapath for LDB-style instructions.
module byte_lane_extract #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sel_hi,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0] w_lane;
  logic       w_fill;

  assign w_lane = i_sel_hi ? i_data[15:8] : i_data[7:0];
  assign w_fill = i_signed & w_lane[7];
  assign o_data = {{(DATA_W-8){w_fill}}, w_lane};

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: sequences instruction fetches and data loads/stores
// over one memory port with variable latency, byte lanes, extension,
// misalignment detection and an ack timeout.
//
// Bus handshake: mem_req is held high for the whole access with mem_addr,
// mem_we, mem_be and mem_wdata stable; the access completes in the cycle
// mem_ack is sampled high, and mem_rdata is valid in that same cycle.
// mem_ack is ignored whenever mem_req is low.
module mem_access_unit
  import cr16_mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] st_data,
  input  logic              size_byte,
  input  logic              ld_signed,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] instr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  op_t               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_byte;
  logic              r_signed;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_be;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_instr;

  logic              w_any_req;
  op_t               w_op;
  logic              w_byte;
  logic              w_misalign;
  logic              w_timeout;
  logic              w_accept;
  logic [DATA_W-1:0] w_wdata_fmt;
  logic [DATA_W-1:0] w_ext;

  assign w_any_req  = st_req | ld_req | fetch_req;
  assign w_byte     = (w_op != OP_FETCH) & size_byte;
  assign w_misalign = addr_in[0] & ~w_byte;
  assign w_timeout  = (r_cnt == CNT_LAST) & ~mem_ack;
  assign w_accept   = (r_state == ST_IDLE) & w_any_req;

  // Request arbitration: store beats load beats fetch; losers are dropped.
  always_comb begin
    w_op = OP_FETCH;
    if (st_req)      w_op = OP_STORE;
    else if (ld_req) w_op = OP_LOAD;
  end

  // Store data formatting: a byte store replicates the low byte on both lanes.
  always_comb begin
    w_wdata_fmt = st_data;
    if (w_byte) begin
      w_wdata_fmt        = '0;
      w_wdata_fmt[15:0]  = {st_data[7:0], st_data[7:0]};
    end
  end

  byte_lane_extract #(
    .DATA_W (DATA_W)
  ) u_lane (
    .i_data   (mem_rdata),
    .i_sel_hi (r_addr[0]),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next_state = w_misalign ? ST_ERR : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem_ack)        w_next_state = ST_DONE;
        else if (w_timeout) w_next_state = ST_ERR;
      end
      ST_DONE: w_next_state = ST_IDLE;
      ST_ERR:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; bus strobes only during ACCESS.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_be  = 2'b00;
    case (r_state)
      ST_ACCESS: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = (r_op == OP_STORE);
        mem_be  = r_be;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ST_ERR:  err = 1'b1;
      default: ;
    endcase
  end

  // Operation latch (MAR/MDR), wait counter and result capture on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_FETCH;
      r_addr   <= '0;
      r_byte   <= 1'b0;
      r_signed <= 1'b0;
      r_wdata  <= '0;
      r_be     <= 2'b00;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_instr  <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= w_op;
        r_addr   <= addr_in;
        r_byte   <= w_byte;
        r_signed <= ld_signed;
        r_wdata  <= w_wdata_fmt;
        r_be     <= lane_be(w_byte, addr_in[0]);
        r_cnt    <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (mem_ack) begin
          if (r_op == OP_FETCH)     r_instr <= mem_rdata;
          else if (r_op == OP_LOAD) r_rdata <= r_byte ? w_ext : mem_rdata;
        end else if (!w_timeout) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign instr     = r_instr;
  assign dbg_state = r_state;

endmodule
